// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and
// default table geometry.
package bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } bp_ctr_e;

    localparam int BP_ENTRIES_DEF = 16;
    localparam int BP_ADDR_W_DEF  = 16;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic of a 2-bit saturating taken/not-taken counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  bp_ctr_e ctr_i,
    input  logic    taken_i,
    output bp_ctr_e ctr_o
);

    // Step one state toward the resolved outcome, pinned at both ends.
    always_comb begin
        ctr_o = CTR_WNT;
        case (ctr_i)
            CTR_SNT: ctr_o = taken_i ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_o = taken_i ? CTR_WT  : CTR_SNT;
            CTR_WT:  ctr_o = taken_i ? CTR_ST  : CTR_WNT;
            CTR_ST:  ctr_o = taken_i ? CTR_ST  : CTR_WT;
            default: ctr_o = CTR_WNT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters and the IF->ID
// prediction register. Define BP_STATS_EN to add saturating update statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES_DEF,
    parameter int ADDR_W  = BP_ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              predict_o,
    output logic [ADDR_W-1:0] target_o,
    output logic              prediction_id_o,
`ifdef BP_STATS_EN
    output logic [15:0]       stat_total_o,
    output logic [15:0]       stat_wrong_o,
`endif
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              ifbranch_i,
    input  logic              precorrc_i,
    input  logic              prewrong_i
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    bp_ctr_e           ctr_q    [ENTRIES];

    logic [IDX_W-1:0]  rd_idx_s;
    logic              rd_hit_s;
    logic [IDX_W-1:0]  upd_idx_s;
    logic [TAG_W-1:0]  upd_tag_s;
    logic              upd_en_s;
    logic              upd_hit_s;
    bp_ctr_e           upd_ctr_s;
    bp_ctr_e           ctr_next_s;

    logic              entry_we_d;
    logic [ADDR_W-1:0] entry_target_d;
    bp_ctr_e           entry_ctr_d;

    logic              pred_id_d;
    logic              pred_id_q;

    assign rd_idx_s  = pc_i[IDX_W-1:0];
    assign upd_idx_s = upd_pc_i[IDX_W-1:0];
    assign upd_tag_s = upd_pc_i[ADDR_W-1:IDX_W];
    assign upd_ctr_s = ctr_q[upd_idx_s];

    bp_sat_counter u_sat_counter (
        .ctr_i   (upd_ctr_s),
        .taken_i (ifbranch_i),
        .ctr_o   (ctr_next_s)
    );

    // Zero-latency lookup reads the table state before any same-cycle write.
    always_comb begin
        rd_hit_s  = valid_q[rd_idx_s] && (tag_q[rd_idx_s] == pc_i[ADDR_W-1:IDX_W]);
        predict_o = rd_hit_s && ctr_q[rd_idx_s][1];
        if (predict_o) begin
            target_o = target_q[rd_idx_s];
        end else begin
            target_o = {ADDR_W{1'b0}};
        end
    end

    // Resolve the write: correct and wrong predictions train the entry identically,
    // so a simultaneous correct/wrong pair collapses onto the same path.
    always_comb begin
        upd_en_s       = precorrc_i | prewrong_i;
        upd_hit_s      = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
        entry_we_d     = 1'b0;
        entry_target_d = target_q[upd_idx_s];
        entry_ctr_d    = upd_ctr_s;
        if (upd_en_s && upd_hit_s) begin
            entry_we_d  = 1'b1;
            entry_ctr_d = ctr_next_s;
            if (ifbranch_i) begin
                entry_target_d = upd_target_i;
            end else begin
                entry_target_d = target_q[upd_idx_s];
            end
        end else if (upd_en_s && ifbranch_i) begin
            entry_we_d     = 1'b1;
            entry_ctr_d    = CTR_WT;
            entry_target_d = upd_target_i;
        end else begin
            entry_we_d = 1'b0;
        end
    end

    // Table storage; a miss-taken write allocates/replaces the whole entry.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= {TAG_W{1'b0}};
                target_q[i] <= {ADDR_W{1'b0}};
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (entry_we_d) begin
            valid_q[upd_idx_s]  <= 1'b1;
            tag_q[upd_idx_s]    <= upd_tag_s;
            target_q[upd_idx_s] <= entry_target_d;
            ctr_q[upd_idx_s]    <= entry_ctr_d;
        end
    end

    // IF->ID prediction register: flush beats stall beats load.
    always_comb begin
        if (flush_i) begin
            pred_id_d = 1'b0;
        end else if (stall_i) begin
            pred_id_d = pred_id_q;
        end else begin
            pred_id_d = predict_o;
        end
    end

    // Prediction register state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pred_id_q <= 1'b0;
        end else begin
            pred_id_q <= pred_id_d;
        end
    end

    assign prediction_id_o = pred_id_q;

`ifdef BP_STATS_EN
    logic [15:0] stat_total_d;
    logic [15:0] stat_total_q;
    logic [15:0] stat_wrong_d;
    logic [15:0] stat_wrong_q;

    // Saturating statistics of resolved and mispredicted branches.
    always_comb begin
        if (upd_en_s) begin
            stat_total_d = sat_inc16(stat_total_q);
        end else begin
            stat_total_d = stat_total_q;
        end
        if (prewrong_i) begin
            stat_wrong_d = sat_inc16(stat_wrong_q);
        end else begin
            stat_wrong_d = stat_wrong_q;
        end
    end

    // Statistics state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stat_total_q <= 16'd0;
            stat_wrong_q <= 16'd0;
        end else begin
            stat_total_q <= stat_total_d;
            stat_wrong_q <= stat_wrong_d;
        end
    end

    assign stat_total_o = stat_total_q;
    assign stat_wrong_o = stat_wrong_q;
`endif

endmodule
